// File: rtl/mantissa_mult_iter.sv
//------------------------------------------------------------------------------
// Module      : mantissa_mult_iter
// Description : Iterative W x W unsigned mantissa multiplier with SIMD lane
//               modes. One SUB-bit chunk of A is multiplied by every SUB-bit
//               chunk of B per cycle; cross-lane partial products are masked,
//               shifted into place and accumulated over N = W/SUB cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mantissa_mult_iter #(
  parameter int W   = 28,
  parameter int SUB = 7,
  parameter int OPW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out
);

  localparam int N  = W / SUB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [OPW-1:0] MODE_FULL = OPW'(0);
  localparam logic [OPW-1:0] MODE_HALF = OPW'(1);
  localparam logic [OPW-1:0] MODE_LANE = OPW'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [OPW-1:0]     mode_q;
  logic [2*W-1:0]     acc;
  logic [CW-1:0]      cnt;
  logic [SUB-1:0]     a_chunk;
  logic [2*W-1:0]     part [N];
  logic [2*W-1:0]     row_sum;

  // Two indices share a lane when the current mode maps them to the same lane.
  function automatic logic same_lane(input logic [OPW-1:0] m, input int i, input int j);
    case (m)
      MODE_HALF: return (i >= N/2) == (j >= N/2);
      MODE_LANE: return i == j;
      default:   return 1'b1;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (cnt == CW'(N-1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Select the A chunk for the current row.
  always_comb begin
    a_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) a_chunk = a_q[i*SUB +: SUB];
    end
  end

  // One sub-multiplier per B chunk; products outside the row's lane are zeroed.
  for (genvar j = 0; j < N; j++) begin : g_sub
    logic [2*SUB-1:0] prod;
    logic             keep;
    assign prod    = (2*SUB)'(a_chunk) * (2*SUB)'(b_q[j*SUB +: SUB]);
    assign keep    = same_lane(mode_q, int'(cnt), j);
    assign part[j] = keep ? ((2*W)'(prod) << (SUB * (int'(cnt) + j))) : '0;
  end

  // Sum of the aligned partial products for this row.
  always_comb begin
    row_sum = '0;
    for (int j = 0; j < N; j++) row_sum = row_sum + part[j];
  end

  // Operand capture, accumulation and row counter; cnt wraps to 0 entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_FULL;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_IDLE && in_valid) begin
      a_q    <= A;
      b_q    <= B;
      mode_q <= (op == MODE_HALF || op == MODE_LANE) ? op : MODE_FULL;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_BUSY) begin
      acc    <= acc + row_sum;
      cnt    <= cnt + 1'b1;
    end
  end

  assign out = acc;

endmodule

`default_nettype wire

// File: tb/tb_mantissa_mult_iter.sv
//------------------------------------------------------------------------------
// Module      : tb_mantissa_mult_iter
// Description : Self-checking bench for mantissa_mult_iter (W=28, SUB=7).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mantissa_mult_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] a_in;
  logic [27:0] b_in;
  logic [1:0]  op_in;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] out;

  int checks = 0;
  int errors = 0;

  mantissa_mult_iter #(.W(28), .SUB(7), .OPW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .op        (op_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [27:0] a;
    logic [27:0] b;
    logic [55:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent per-lane reference: slice lanes, multiply, place in 2*LW fields.
  function automatic logic [55:0] ref_model(input logic [1:0] o, input logic [27:0] a, input logic [27:0] b);
    longint unsigned res = 0;
    longint unsigned m, al, bl;
    int lw = (o == 2'b01) ? 14 : (o == 2'b10) ? 7 : 28;
    m = (64'd1 << lw) - 1;
    for (int l = 0; l < 28 / lw; l++) begin
      al  = (64'(a) >> (l * lw)) & m;
      bl  = (64'(b) >> (l * lw)) & m;
      res = res | ((al * bl) << (2 * l * lw));
    end
    return res[55:0];
  endfunction

  // Full transaction starting at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [27:0] a, input logic [27:0] b,
                        input logic [55:0] exp, input int stall, input string tag);
    int   lat;
    logic ready_in_busy;
    chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a_in = a; b_in = b; op_in = o;
    @(negedge clk);
    in_valid = 1'b0; a_in = 28'($urandom); b_in = 28'($urandom); op_in = 2'($urandom);
    lat = 0;
    ready_in_busy = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) ready_in_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " in_ready_busy"}, 64'(ready_in_busy), 64'd0);
    for (int s = 0; s < stall; s++) begin
      chk({tag, " stall_out"}, 64'(out), 64'(exp));
      chk({tag, " stall_valid_ready"}, {62'd0, out_valid, in_ready}, 64'd2);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk({tag, " out"}, 64'(out), 64'(exp));
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " post_handshake"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{2'b00, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001};
    vecs[1] = '{2'b01, {14'h3FFF, 14'h0002}, {14'h0003, 14'h0005}, 56'h000BFFD000000A};
    vecs[2] = '{2'b10, {7'd127, 7'd1, 7'd0, 7'd5}, {7'd127, 7'd100, 7'd9, 7'd3},
                {14'd16129, 14'd100, 14'd0, 14'd15}};
    vecs[3] = '{2'b11, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001};
    vecs[4] = '{2'b00, 28'h0000001, 28'hFFFFFFF, 56'h0000000FFFFFFF};
    vecs[5] = '{2'b01, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFF8001FFF8001};
    vecs[6] = '{2'b10, 28'hFFFFFFF, 28'hFFFFFFF, {4{14'h3F01}}};
    vecs[7] = '{2'b10, {7'd1, 7'd2, 7'd3, 7'd4}, {7'd5, 7'd6, 7'd7, 7'd8},
                {14'd5, 14'd12, 14'd21, 14'd32}};
    vecs[8] = '{2'b00, 28'd0, 28'hABCDEF1, 56'd0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_valid_ready", {62'd0, out_valid, in_ready}, 64'd1);
    rst = 1'b0;

    // Directed table, no backpressure, back-to-back.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));
    end

    // Backpressure for 3 cycles with in_valid pulses, then immediate re-accept.
    run_op(2'b01, {14'h3FFF, 14'h0002}, {14'h0003, 14'h0005}, 56'h000BFFD000000A, 3, "stall");
    run_op(2'b00, 28'h0000003, 28'h0000005, 56'd15, 0, "b2b");

    // Reset while BUSY with cnt == 2.
    in_valid = 1'b1; a_in = 28'hFFFFFFF; b_in = 28'hFFFFFFF; op_in = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_out", 64'(out), 64'd0);
    chk("midreset_valid_ready", {62'd0, out_valid, in_ready}, 64'd1);
    run_op(2'b10, {7'd1, 7'd2, 7'd3, 7'd4}, {7'd5, 7'd6, 7'd7, 7'd8},
           {14'd5, 14'd12, 14'd21, 14'd32}, 1, "after_reset");

    // Randomised ops over all modes with random stalls.
    for (int k = 0; k < 1000; k++) begin
      logic [1:0]  o;
      logic [27:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = 28'($urandom);
      b = 28'($urandom);
      run_op(o, a, b, ref_model(o, a, b), int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
